gerador_indice: RTL and testbench



---
 rtl/gerador_indice.sv | 94 +++++++++
 tb/tb_gerador_indice.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gerador_indice.sv
// gerador_indice: draws a pseudo-random question index that has not been used yet in the current game.
// Ports: clock/reset (sync, active-high); zeraI clears the used bitmap and aborts any search;
// contaI steps the LFSR; gera is the level request; indice/indiceReady hold the granted index;
// esgotado flags an exhausted pool; db_estado exposes the FSM state.
module gerador_indice #(
    parameter int N_PERGUNTAS = 16,
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zeraI,
    input  logic             contaI,
    input  logic             gera,
    output logic [IDX_W-1:0] indice,
    output logic             indiceReady,
    output logic             esgotado,
    output logic [3:0]       db_estado
);
    localparam int CW = $clog2(N_PERGUNTAS + 1);
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_PERGUNTAS);
    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_PERGUNTAS - 1);
    localparam logic [CW-1:0] N_CNT = CW'(N_PERGUNTAS);

    typedef enum logic [1:0] {OCIOSO = 2'd0, PROCURA = 2'd1, PRONTO = 2'd2} estado_t;

    estado_t r_estado, w_proximo;
    logic [7:0] r_lfsr;
    logic [N_PERGUNTAS-1:0] r_usados;
    logic [CW-1:0] r_cont;
    logic [IDX_W-1:0] r_sonda, w_raw, w_cand;
    logic w_limpa, w_marca, w_avanca;

    // Fold raw LFSR bits that fall outside the pool back into range
    assign w_raw = r_lfsr[IDX_W-1:0];
    assign w_cand = ({1'b0, w_raw} >= N_EXT) ? w_raw - N_EXT[IDX_W-1:0] : w_raw;
    assign db_estado = {2'b00, r_estado};

    always_comb begin
        w_proximo = OCIOSO;
        case (r_estado)
            OCIOSO:  w_proximo = gera ? PROCURA : OCIOSO;
            PROCURA: w_proximo = !gera ? OCIOSO : (r_usados[r_sonda] ? PROCURA : PRONTO);
            PRONTO:  w_proximo = gera ? PRONTO : OCIOSO;
            default: w_proximo = OCIOSO;
        endcase
        // An exhausted pool is recycled at the moment a new request is accepted
        w_limpa = (r_estado == OCIOSO) && gera && esgotado;
        w_marca = (r_estado == PROCURA) && gera && !r_usados[r_sonda];
        w_avanca = (r_estado == PROCURA) && gera && r_usados[r_sonda];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_lfsr <= 8'h01;
            r_usados <= '0;
            r_cont <= '0;
            r_sonda <= '0;
            indice <= '0;
            indiceReady <= 1'b0;
            esgotado <= 1'b0;
        end else begin
            // The LFSR keeps running through zeraI so game clears do not repeat sequences
            if (contaI)
                r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            if (zeraI) begin
                r_estado <= OCIOSO;
                r_usados <= '0;
                r_cont <= '0;
                indice <= '0;
                indiceReady <= 1'b0;
                esgotado <= 1'b0;
            end else begin
                r_estado <= w_proximo;
                indiceReady <= (w_proximo == PRONTO);
                if (r_estado == OCIOSO && gera)
                    r_sonda <= w_cand;
                if (w_avanca)
                    r_sonda <= (r_sonda == ULTIMO) ? '0 : r_sonda + 1'b1;
                if (w_limpa) begin
                    r_usados <= '0;
                    r_cont <= '0;
                    esgotado <= 1'b0;
                end
                if (w_marca) begin
                    r_usados[r_sonda] <= 1'b1;
                    r_cont <= r_cont + 1'b1;
                    esgotado <= (r_cont + 1'b1 == N_CNT);
                    indice <= r_sonda;
                end
            end
        end
    end
endmodule

// File: tb/tb_gerador_indice.sv
// tb_gerador_indice: checks gerador_indice (N=16 and N=10 instances) against a pool/bitmap reference model.
module tb_gerador_indice;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic gera[2], conta[2], zera[2];
    logic [3:0] idx[2];
    logic rdy[2], esg[2];
    logic [3:0] est[2];

    gerador_indice #(.N_PERGUNTAS(16), .IDX_W(4)) dut_a (
        .clock(clk), .reset(rst), .zeraI(zera[0]), .contaI(conta[0]), .gera(gera[0]),
        .indice(idx[0]), .indiceReady(rdy[0]), .esgotado(esg[0]), .db_estado(est[0])
    );
    gerador_indice #(.N_PERGUNTAS(10), .IDX_W(4)) dut_b (
        .clock(clk), .reset(rst), .zeraI(zera[1]), .contaI(conta[1]), .gera(gera[1]),
        .indice(idx[1]), .indiceReady(rdy[1]), .esgotado(esg[1]), .db_estado(est[1])
    );

    int checks = 0;
    int failures = 0;
    int nq[2] = '{16, 10};
    logic [7:0] m_lfsr[2];
    bit m_used[2][16];
    int m_cnt[2];
    int m_last[2];

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always @(posedge clk) begin
        m_lfsr[0] <= rst ? 8'h01 : (conta[0] ? lstep(m_lfsr[0]) : m_lfsr[0]);
        m_lfsr[1] <= rst ? 8'h01 : (conta[1] ? lstep(m_lfsr[1]) : m_lfsr[1]);
    end

    task automatic m_clear(input int d);
        for (int i = 0; i < 16; i++) m_used[d][i] = 1'b0;
        m_cnt[d] = 0;
    endtask

    // Drives one full request/grant/release handshake and reports observed and modelled results
    task automatic run_req(input int d, input bit cta, input int hold,
                           output int lat, output int exp_lat, output int got_idx, output int exp_idx,
                           output bit got_esg, output bit exp_esg, output bit held_ok, output bit fell_ok);
        int p;
        @(negedge clk);
        conta[d] = cta;
        gera[d] = 1'b1;
        p = int'(m_lfsr[d][3:0]);
        if (p >= nq[d]) p -= nq[d];
        if (m_cnt[d] == nq[d]) m_clear(d);
        exp_lat = 1;
        for (int g = 0; g < nq[d] && m_used[d][p]; g++) begin
            p = (p + 1) % nq[d];
            exp_lat++;
        end
        exp_idx = p;
        m_used[d][p] = 1'b1;
        m_cnt[d]++;
        m_last[d] = p;
        exp_esg = (m_cnt[d] == nq[d]);
        lat = -1;
        for (int e = 0; e < nq[d] + 3 && lat < 0; e++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) lat = e;
        end
        got_idx = int'(idx[d]);
        got_esg = esg[d];
        held_ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (rdy[d] !== 1'b1 || idx[d] !== 4'(exp_idx)) held_ok = 1'b0;
        end
        gera[d] = 1'b0;
        @(negedge clk);
        fell_ok = (rdy[d] === 1'b0) && (est[d] === 4'd0);
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            checks++; if (idx[d] !== 4'd0) begin failures++; $display("FAIL reset_idx[%0d] got=%0d exp=0", d, idx[d]); end
            checks++; if (rdy[d] !== 1'b0) begin failures++; $display("FAIL reset_rdy[%0d] got=%b exp=0", d, rdy[d]); end
            checks++; if (esg[d] !== 1'b0) begin failures++; $display("FAIL reset_esg[%0d] got=%b exp=0", d, esg[d]); end
            checks++; if (est[d] !== 4'd0) begin failures++; $display("FAIL reset_est[%0d] got=%0d exp=0", d, est[d]); end
        end
    endtask

    task automatic test_first_requests;
        int l, el, gi, ei;
        bit ge, ee, h, f;
        for (int r = 0; r < 2; r++) begin
            run_req(0, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
            checks++; if (l !== el) begin failures++; $display("FAIL first_lat r=%0d got=%0d exp=%0d", r, l, el); end
            checks++; if (gi !== ei) begin failures++; $display("FAIL first_idx r=%0d got=%0d exp=%0d", r, gi, ei); end
            checks++; if (gi !== r + 1) begin failures++; $display("FAIL first_idx_const r=%0d got=%0d exp=%0d", r, gi, r + 1); end
            checks++; if (ge !== ee) begin failures++; $display("FAIL first_esg r=%0d got=%b exp=%b", r, ge, ee); end
            checks++; if (!f) begin failures++; $display("FAIL first_release r=%0d rdy=%b est=%0d exp rdy=0 est=0", r, rdy[0], est[0]); end
        end
    endtask

    task automatic test_hold;
        int l, el, gi, ei;
        bit ge, ee, h, f;
        run_req(0, 1'b0, 6, l, el, gi, ei, ge, ee, h, f);
        checks++; if (gi !== ei) begin failures++; $display("FAIL hold_idx got=%0d exp=%0d", gi, ei); end
        checks++; if (!h) begin failures++; $display("FAIL hold_stable got=unstable exp=stable idx=%0d", ei); end
        checks++; if (!f) begin failures++; $display("FAIL hold_release rdy=%b est=%0d exp rdy=0 est=0", rdy[0], est[0]); end
        run_req(0, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
        checks++; if (l !== el) begin failures++; $display("FAIL hold_next_lat got=%0d exp=%0d", l, el); end
        checks++; if (gi !== ei) begin failures++; $display("FAIL hold_next_idx got=%0d exp=%0d", gi, ei); end
    endtask

    task automatic test_exhaust;
        int l, el, gi, ei;
        bit ge, ee, h, f;
        while (m_cnt[0] < 16) begin
            run_req(0, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
            checks++; if (l !== el) begin failures++; $display("FAIL exhaust_lat got=%0d exp=%0d", l, el); end
            checks++; if (gi !== ei) begin failures++; $display("FAIL exhaust_idx got=%0d exp=%0d", gi, ei); end
            checks++; if (ge !== ee) begin failures++; $display("FAIL exhaust_esg got=%b exp=%b", ge, ee); end
        end
        run_req(0, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
        checks++; if (l !== 1) begin failures++; $display("FAIL recycle_lat got=%0d exp=1", l); end
        checks++; if (gi !== 1) begin failures++; $display("FAIL recycle_idx got=%0d exp=1", gi); end
        checks++; if (ge !== 1'b0) begin failures++; $display("FAIL recycle_esg got=%b exp=0", ge); end
    endtask

    task automatic test_wrap_n10;
        int l, el, gi, ei;
        bit ge, ee, h, f;
        for (int r = 0; r < 10; r++) begin
            run_req(1, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
            checks++; if (l !== el) begin failures++; $display("FAIL wrap_lat r=%0d got=%0d exp=%0d", r, l, el); end
            checks++; if (gi !== ei) begin failures++; $display("FAIL wrap_idx r=%0d got=%0d exp=%0d", r, gi, ei); end
            checks++; if (ge !== ee) begin failures++; $display("FAIL wrap_esg r=%0d got=%b exp=%b", r, ge, ee); end
        end
        checks++; if (gi !== 0 || l !== 10) begin failures++; $display("FAIL wrap_final got idx=%0d lat=%0d exp idx=0 lat=10", gi, l); end
    endtask

    task automatic test_abort;
        int l, el, gi, ei;
        bit ge, ee, h, f;
        @(negedge clk);
        conta[0] = 1'b0;
        gera[0] = 1'b1;
        @(negedge clk);
        checks++; if (est[0] !== 4'd1) begin failures++; $display("FAIL abort_search_state got=%0d exp=1", est[0]); end
        gera[0] = 1'b0;
        @(negedge clk);
        checks++; if (est[0] !== 4'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", est[0]); end
        checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL abort_rdy got=%b exp=0", rdy[0]); end
        checks++; if (idx[0] !== 4'(m_last[0])) begin failures++; $display("FAIL abort_idx got=%0d exp=%0d", idx[0], m_last[0]); end
        run_req(0, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
        checks++; if (l !== el || gi !== ei) begin failures++; $display("FAIL abort_next got lat=%0d idx=%0d exp lat=%0d idx=%0d", l, gi, el, ei); end
    endtask

    task automatic test_zera;
        int l, el, gi, ei;
        bit ge, ee, h, f;
        @(negedge clk);
        gera[0] = 1'b1;
        @(negedge clk);
        checks++; if (est[0] !== 4'd1) begin failures++; $display("FAIL zera_pre_state got=%0d exp=1", est[0]); end
        zera[0] = 1'b1;
        @(negedge clk);
        checks++; if (est[0] !== 4'd0) begin failures++; $display("FAIL zera_state got=%0d exp=0", est[0]); end
        checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL zera_rdy got=%b exp=0", rdy[0]); end
        checks++; if (idx[0] !== 4'd0) begin failures++; $display("FAIL zera_idx got=%0d exp=0", idx[0]); end
        checks++; if (esg[0] !== 1'b0) begin failures++; $display("FAIL zera_esg got=%b exp=0", esg[0]); end
        zera[0] = 1'b0;
        gera[0] = 1'b0;
        m_clear(0);
        m_last[0] = 0;
        run_req(0, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
        checks++; if (l !== el || gi !== ei) begin failures++; $display("FAIL zera_next got lat=%0d idx=%0d exp lat=%0d idx=%0d", l, gi, el, ei); end
    endtask

    task automatic test_reset_mid;
        int l, el, gi, ei;
        bit ge, ee, h, f;
        @(negedge clk);
        gera[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (idx[d] !== 4'd0 || rdy[d] !== 1'b0 || esg[d] !== 1'b0 || est[d] !== 4'd0)
                begin failures++; $display("FAIL reset_mid[%0d] got idx=%0d rdy=%b esg=%b est=%0d exp all 0", d, idx[d], rdy[d], esg[d], est[d]); end
            m_clear(d);
            m_last[d] = 0;
        end
        rst = 1'b0;
        gera[0] = 1'b0;
        run_req(0, 1'b0, 0, l, el, gi, ei, ge, ee, h, f);
        checks++; if (gi !== 1 || l !== 1) begin failures++; $display("FAIL reset_mid_next got idx=%0d lat=%0d exp idx=1 lat=1", gi, l); end
    endtask

    task automatic test_random;
        int l, el, gi, ei, d;
        bit ge, ee, h, f;
        for (int r = 0; r < 40; r++) begin
            d = int'($urandom_range(0, 1));
            run_req(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), l, el, gi, ei, ge, ee, h, f);
            checks++; if (l !== el) begin failures++; $display("FAIL rand_lat d=%0d r=%0d got=%0d exp=%0d", d, r, l, el); end
            checks++; if (gi !== ei) begin failures++; $display("FAIL rand_idx d=%0d r=%0d got=%0d exp=%0d", d, r, gi, ei); end
            checks++; if (ge !== ee) begin failures++; $display("FAIL rand_esg d=%0d r=%0d got=%b exp=%b", d, r, ge, ee); end
            checks++; if (!h) begin failures++; $display("FAIL rand_hold d=%0d r=%0d got=unstable exp=stable", d, r); end
            checks++; if (!f) begin failures++; $display("FAIL rand_release d=%0d r=%0d rdy=%b est=%0d exp rdy=0 est=0", d, r, rdy[d], est[d]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            gera[d] = 1'b0;
            conta[d] = 1'b0;
            zera[d] = 1'b0;
            m_clear(d);
            m_last[d] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_first_requests();
        test_hold();
        test_exhaust();
        test_wrap_n10();
        test_abort();
        test_zera();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
